// File: rtl/ps_line_feeder.sv
// rtl/ps_line_feeder.sv - line-granular scheduler from the pixel FIFO to the kernel controller
//
// Purpose:
//   Waits in IDLE for a kernel-controller request. Each accepted request pops
//   exactly one line of LINE_WIDTH pixels from the upstream FIFO and forwards
//   it as a valid-qualified pixel stream. The line position within the frame
//   is tracked, and a one-cycle pulse marks the end of each frame.
//
// Parameters:
//   LINE_WIDTH   pixels per line (pops per granted request)
//   FRAME_LINES  lines per frame (line counter wrap point, <= 512)
//   GAP_CYCLES   idle cycles after each line before i_req is resampled (2..15)
//
// Ports:
//   i_clk         clock
//   i_rstn        asynchronous active-low reset
//   i_enable      run enable, sampled only in IDLE
//   i_fifo_empty  upstream FIFO empty flag
//   i_fifo_rdata  FIFO read data, valid the cycle after o_fifo_rd
//   o_fifo_rd     FIFO pop strobe (combinational)
//   i_req         level request from the kernel controller
//   o_data        pixel to the kernel controller (registered)
//   o_valid       o_data qualifier (registered)
//   o_busy        high in any state other than IDLE
//   o_line_cnt    index of the next line to be sent
//   o_frame_done  one-cycle pulse after the last line of a frame

module ps_line_feeder #(
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480,
  parameter int GAP_CYCLES  = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_enable,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_rdata,
  output logic       o_fifo_rd,
  input  logic       i_req,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic [8:0] o_line_cnt,
  output logic       o_frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [9:0] PIX_END   = 10'(LINE_WIDTH);
  localparam logic [9:0] PIX_LAST  = 10'(LINE_WIDTH - 1);
  localparam logic [8:0] LINE_LAST = 9'(FRAME_LINES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

  logic [1:0] state;
  logic [9:0] pix_cnt;
  logic [3:0] gap_cnt;
  logic [8:0] line_cnt;
  logic       rd_q;
  logic       valid_q;
  logic [7:0] data_q;
  logic       frame_done_q;

  logic       pop;
  logic       line_end;

  // The pix_cnt bound is redundant with the LOAD->GAP transition but keeps
  // the pop count capped at LINE_WIDTH even if the FIFO holds more data.
  assign pop      = (state == S_LOAD) && !i_fifo_empty && (pix_cnt < PIX_END);
  assign line_end = pop && (pix_cnt == PIX_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= S_IDLE;
      pix_cnt      <= 10'd0;
      gap_cnt      <= 4'd0;
      line_cnt     <= 9'd0;
      rd_q         <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      // Two-stage read pipeline: pop -> FIFO data cycle -> registered output.
      rd_q    <= pop;
      valid_q <= rd_q;
      if (rd_q) begin
        data_q <= i_fifo_rdata;
      end

      frame_done_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_enable && i_req) begin
            state   <= S_LOAD;
            pix_cnt <= 10'd0;
          end
        end

        S_LOAD: begin
          // Requests and enable are ignored here: a started line always completes.
          if (pop) begin
            pix_cnt <= pix_cnt + 10'd1;
          end
          if (line_end) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
            if (line_cnt == LINE_LAST) begin
              line_cnt     <= 9'd0;
              frame_done_q <= 1'b1;
            end else begin
              line_cnt <= line_cnt + 9'd1;
            end
          end
        end

        S_GAP: begin
          // The gap lets the last pixels drain and the controller update its
          // registered request before it is sampled again in IDLE.
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_rd    = pop;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state != S_IDLE);
  assign o_line_cnt   = line_cnt;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_ps_line_feeder.sv
// tb/tb_ps_line_feeder.sv - self-checking bench for ps_line_feeder

module tb_ps_line_feeder;

  localparam int LW = 8;
  localparam int FL = 4;
  localparam int GC = 3;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b1;
  logic       i_enable = 1'b0;
  logic       i_fifo_empty = 1'b1;
  logic [7:0] i_fifo_rdata = 8'd0;
  logic       o_fifo_rd;
  logic       i_req = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic [8:0] o_line_cnt;
  logic       o_frame_done;

  always #5 i_clk = ~i_clk;

  ps_line_feeder #(
    .LINE_WIDTH(LW),
    .FRAME_LINES(FL),
    .GAP_CYCLES(GC)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_enable(i_enable),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_rdata(i_fifo_rdata),
    .o_fifo_rd(o_fifo_rd),
    .i_req(i_req),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_line_cnt(o_line_cnt),
    .o_frame_done(o_frame_done)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  int         val_cyc[$];
  int         lc_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   npop = 0;
  int   nvalid = 0;
  int   fd_pulses = 0;
  int   fd_cyc = -1;
  int   busy_fall = -1;
  int   next_byte = 0;
  int   base;
  logic rd_seen = 1'b0;
  logic force_empty = 1'b0;
  logic prev_busy = 1'b0;
  logic [8:0] prev_lc = 9'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Every byte loaded into the FIFO model is also the next expected output.
  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(8'(next_byte));
      exp_q.push_back(8'(next_byte));
      next_byte = (next_byte + 1) % 256;
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
    cycle++;
    if (rd_seen && fifo_q.size() > 0) i_fifo_rdata = fifo_q.pop_front();
    if (o_valid === 1'b1) begin
      nvalid++;
      val_cyc.push_back(cycle);
      if (exp_q.size() == 0) chk("valid_unexpected", 32'(o_valid), 32'd0);
      else chk("data", 32'(o_data), 32'(exp_q.pop_front()));
    end
    if (o_frame_done === 1'b1) begin
      fd_pulses++;
      fd_cyc = cycle;
    end
    if (prev_busy && !o_busy) busy_fall = cycle;
    prev_busy = o_busy;
    if (o_line_cnt !== prev_lc) begin
      lc_q.push_back(int'(o_line_cnt));
      prev_lc = o_line_cnt;
    end
    i_fifo_empty = (fifo_q.size() == 0) || force_empty;
    #1;
    rd_seen = o_fifo_rd;
    if (rd_seen) begin
      npop++;
      pop_cyc.push_back(cycle);
      chk("pop_while_empty", 32'(i_fifo_empty), 32'd0);
    end
  endtask

  task automatic wait_pops(input string tag, input int target, input int limit);
    int n = 0;
    while (npop < target && n < limit) begin
      cyc();
      n++;
    end
    chk(tag, 32'(npop >= target), 32'd1);
  endtask

  initial begin
    // Reset state
    i_rstn = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_line_cnt", 32'(o_line_cnt), 32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    chk("rst_fifo_rd", 32'(o_fifo_rd), 32'd0);
    i_rstn = 1'b1;
    repeat (2) cyc();
    lc_q.delete();
    pop_cyc.delete();
    val_cyc.delete();
    npop = 0;
    nvalid = 0;
    prev_lc = o_line_cnt;

    // Basic line; FIFO holds more than a line
    push_bytes(LW + 4);
    i_enable = 1'b1;
    i_req = 1'b1;
    wait_pops("basic_start", 1, 20);
    i_req = 1'b0;
    wait_pops("basic_line", LW, 40);
    repeat (12) cyc();
    chk("basic_pops", 32'(npop), 32'(LW));
    chk("basic_valids", 32'(nvalid), 32'(LW));
    chk("first_valid_latency", 32'(val_cyc[0] - pop_cyc[0]), 32'd2);
    chk("last_valid_latency", 32'(val_cyc[LW-1] - pop_cyc[LW-1]), 32'd2);
    chk("basic_line_cnt", 32'(o_line_cnt), 32'd1);
    chk("busy_fall", 32'(busy_fall - pop_cyc[LW-1]), 32'(GC + 1));
    chk("basic_busy_end", 32'(o_busy), 32'd0);
    chk("pop_cap_fifo_left", 32'(fifo_q.size()), 32'd4);

    // Three back-to-back lines, wrapping the frame
    push_bytes(3 * LW - 4 + 8);
    i_req = 1'b1;
    wait_pops("triple", 4 * LW, 200);
    i_req = 1'b0;
    repeat (20) cyc();
    chk("triple_pops", 32'(npop), 32'(4 * LW));
    chk("gap_line2_3", 32'(pop_cyc[2*LW] - pop_cyc[2*LW-1]), 32'(GC + 2));
    chk("gap_line3_4", 32'(pop_cyc[3*LW] - pop_cyc[3*LW-1]), 32'(GC + 2));
    chk("line4_contig", 32'(pop_cyc[4*LW-1] - pop_cyc[3*LW]), 32'(LW - 1));
    chk("frame_done_count", 32'(fd_pulses), 32'd1);
    chk("frame_done_cycle", 32'(fd_cyc - pop_cyc[4*LW-1]), 32'd1);

    // Paced single request
    push_bytes(8);
    i_req = 1'b1;
    cyc();
    i_req = 1'b0;
    wait_pops("paced", 5 * LW, 60);
    repeat (20) cyc();
    chk("paced_no_extra_pops", 32'(npop), 32'(5 * LW));
    chk("paced_fifo_left", 32'(fifo_q.size()), 32'd8);
    chk("lc_seq_len", 32'(lc_q.size()), 32'd5);
    if (lc_q.size() == 5) begin
      chk("lc_seq0", 32'(lc_q[0]), 32'd1);
      chk("lc_seq1", 32'(lc_q[1]), 32'd2);
      chk("lc_seq2", 32'(lc_q[2]), 32'd3);
      chk("lc_seq3", 32'(lc_q[3]), 32'd0);
      chk("lc_seq4", 32'(lc_q[4]), 32'd1);
    end

    // Periodic empty flag during LOAD
    base = nvalid;
    i_req = 1'b1;
    for (int i = 0; i < 60 && npop < 6 * LW; i++) begin
      force_empty = ((cycle % 5) == 0);
      cyc();
      if (npop > 5 * LW) i_req = 1'b0;
    end
    force_empty = 1'b0;
    i_req = 1'b0;
    repeat (10) cyc();
    chk("underflow_pops", 32'(npop), 32'(6 * LW));
    chk("underflow_valids", 32'(nvalid - base), 32'(LW));
    chk("underflow_stalled", 32'(pop_cyc[6*LW-1] - pop_cyc[5*LW] > LW - 1), 32'd1);
    chk("underflow_drained", 32'(exp_q.size()), 32'd0);

    // Genuinely empty FIFO mid-line: stall until refilled
    push_bytes(3);
    i_req = 1'b1;
    wait_pops("stall_part", 6 * LW + 3, 30);
    i_req = 1'b0;
    repeat (15) cyc();
    chk("stall_pops", 32'(npop), 32'(6 * LW + 3));
    chk("stall_busy", 32'(o_busy), 32'd1);
    push_bytes(LW - 3);
    wait_pops("stall_resume", 7 * LW, 30);
    repeat (10) cyc();
    chk("stall_done_busy", 32'(o_busy), 32'd0);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);
    chk("stall_line_cnt", 32'(o_line_cnt), 32'd3);

    // Enable dropped mid-line
    push_bytes(LW + 4);
    i_req = 1'b1;
    wait_pops("en_mid", 7 * LW + 3, 20);
    i_enable = 1'b0;
    repeat (30) cyc();
    chk("en_drop_pops", 32'(npop), 32'(8 * LW));
    chk("en_drop_busy", 32'(o_busy), 32'd0);
    chk("en_drop_line_cnt", 32'(o_line_cnt), 32'd0);
    chk("en_drop_frame_done", 32'(fd_pulses), 32'd2);

    // Asynchronous reset mid-line
    push_bytes(2 * LW);
    i_enable = 1'b1;
    wait_pops("pre_rst_line", 9 * LW, 40);
    wait_pops("rst_mid", 9 * LW + 5, 30);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("async_fifo_rd", 32'(o_fifo_rd), 32'd0);
    chk("async_valid", 32'(o_valid), 32'd0);
    chk("async_busy", 32'(o_busy), 32'd0);
    chk("async_line_cnt", 32'(o_line_cnt), 32'd0);
    rd_seen = 1'b0;
    exp_q = fifo_q;
    push_bytes(LW);
    repeat (2) cyc();
    i_rstn = 1'b1;
    base = npop;
    wait_pops("post_rst_line", base + LW, 30);
    i_req = 1'b0;
    repeat (12) cyc();
    chk("post_rst_pops", 32'(npop - base), 32'(LW));
    chk("post_rst_line_cnt", 32'(o_line_cnt), 32'd1);
    chk("post_rst_exp_left", 32'(exp_q.size()), 32'(LW));
    chk("post_rst_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
